// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// oversampling constants and small bit-level helper functions.
package uart_pkg;

    // Oversample ticks per serial bit and the mid-bit tick index.
    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_MID = 8;

    // Receiver FSM states; ST_PARITY is only reachable with UART_RX_PARITY_EN.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    // Two-of-three vote used to filter line noise around mid-bit.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Even-parity bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: first-word-fall-through byte queue with occupancy,
// full/empty flags and a one-cycle overrun pulse for rejected pushes.
// A push alongside a pop of a full FIFO is accepted.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               wdata,
    input  logic                     pop,
    output logic [7:0]               rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] LVL_ZERO = LW'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic [LW-1:0] level_nxt_s;
    logic          empty_r;
    logic          full_r;
    logic          overrun_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    // Pops of an empty FIFO are ignored; a full FIFO only accepts a push
    // when the head is leaving in the same cycle.
    assign pop_ok_s  = pop & ~empty_r;
    assign push_ok_s = push & (~full_r | pop_ok_s);

    // Next occupancy from accepted push/pop; both together leave it unchanged.
    always_comb begin
        level_nxt_s = level_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   level_nxt_s = level_r + LVL_ONE;
            2'b01:   level_nxt_s = level_r - LVL_ONE;
            default: level_nxt_s = level_r;
        endcase
    end

    // Byte storage; contents need no reset because the flags gate visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers, occupancy, registered flags and overrun pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r  <= PTR_ZERO;
            rd_ptr_r  <= PTR_ZERO;
            level_r   <= LVL_ZERO;
            empty_r   <= 1'b1;
            full_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r   <= level_nxt_s;
            empty_r   <= (level_nxt_s == LVL_ZERO);
            full_r    <= (level_nxt_s == DEPTH_L);
            overrun_r <= push & ~push_ok_s;
        end
    end

    // Head byte reads as zero while empty so reset leaves a clean output.
    assign rdata   = empty_r ? 8'h00 : mem_r[rd_ptr_r];
    assign empty   = empty_r;
    assign full    = full_r;
    assign level   = level_r;
    assign overrun = overrun_r;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: line synchronizer, prescaled 16x oversample tick,
// start/data/stop framing FSM with 3-sample majority voting, and a
// receive FIFO. Optional feature macro: UART_RX_PARITY_EN adds an
// even-parity bit after the data bits (11-bit frame); without it the
// frame is 8N1 and parity_err_o stays low.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int PRESCALE_W = 16
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_ni,
    input  logic                          en_i,
    input  logic [PRESCALE_W-1:0]         prescale_i,
    input  logic                          rx_i,
    input  logic                          rd_i,
    output logic [7:0]                    rdata_o,
    output logic                          empty_o,
    output logic                          full_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          frame_err_o,
    output logic                          overrun_o,
    output logic                          parity_err_o,
    output logic                          irq_o
);

    localparam logic [3:0] IDX_S7     = 4'(SAMPLE_MID - 1);
    localparam logic [3:0] IDX_S8     = 4'(SAMPLE_MID);
    localparam logic [3:0] IDX_DECIDE = 4'(SAMPLE_MID + 1);
    localparam logic [3:0] IDX_END    = 4'(OVERSAMPLE - 1);
    localparam logic [PRESCALE_W-1:0] PRESC_ZERO = {PRESCALE_W{1'b0}};
    localparam logic [PRESCALE_W-1:0] PRESC_ONE  = PRESCALE_W'(1);

    logic                  sync1_r;
    logic                  rx_sync_r;
    logic                  rx_prev_r;
    logic [PRESCALE_W-1:0] presc_cnt_r;
    logic                  tick_s;
    rx_state_e             state_r;
    rx_state_e             state_nxt_s;
    logic [3:0]            samp_idx_r;
    logic [2:0]            bit_cnt_r;
    logic [7:0]            shift_r;
    logic                  samp7_r;
    logic                  samp8_r;
    logic                  par_bad_r;
    logic                  fall_s;
    logic                  bit_s;
    logic                  at_decide_s;
    logic                  at_end_s;
    logic                  push_s;
    logic                  frame_err_s;
    logic                  parity_err_s;
    logic                  frame_err_r;
    logic                  parity_err_r;
    logic                  fifo_empty_s;

    // Two-flop line synchronizer plus a delayed copy for edge detection.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            sync1_r   <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            sync1_r   <= rx_i;
            rx_sync_r <= sync1_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    assign fall_s = rx_prev_r & ~rx_sync_r;

    // Oversample prescaler: counts down, reloads at zero; parked at reload while disabled.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            presc_cnt_r <= PRESC_ZERO;
        end else if (!en_i) begin
            presc_cnt_r <= prescale_i;
        end else if (presc_cnt_r == PRESC_ZERO) begin
            presc_cnt_r <= prescale_i;
        end else begin
            presc_cnt_r <= presc_cnt_r - PRESC_ONE;
        end
    end

    assign tick_s      = en_i & (presc_cnt_r == PRESC_ZERO);
    assign at_decide_s = tick_s & (samp_idx_r == IDX_DECIDE);
    assign at_end_s    = tick_s & (samp_idx_r == IDX_END);
    // Bit decision at tick 9: ticks 7 and 8 are stored, tick 9 is live.
    assign bit_s       = maj3(samp7_r, samp8_r, rx_sync_r);

    // FSM state register.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; a disabled receiver always returns to idle.
    always_comb begin
        state_nxt_s = state_r;
        if (!en_i) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (fall_s) begin
                        state_nxt_s = ST_START;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (at_decide_s && bit_s) begin
                        state_nxt_s = ST_IDLE;
                    end else if (at_end_s) begin
                        state_nxt_s = ST_DATA;
                    end else begin
                        state_nxt_s = ST_START;
                    end
                end
                ST_DATA: begin
                    if (at_end_s && (bit_cnt_r == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt_s = ST_PARITY;
`else
                        state_nxt_s = ST_STOP;
`endif
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end
                ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
                    if (at_end_s) begin
                        state_nxt_s = ST_STOP;
                    end else begin
                        state_nxt_s = ST_PARITY;
                    end
`else
                    state_nxt_s = ST_IDLE;
`endif
                end
                ST_STOP: begin
                    if (at_decide_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_STOP;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Frame datapath: tick index, mid-bit samples, data shifter, bit count, parity flag.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            samp_idx_r <= 4'd0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            samp7_r    <= 1'b1;
            samp8_r    <= 1'b1;
            par_bad_r  <= 1'b0;
        end else if ((state_r == ST_IDLE) || !en_i) begin
            samp_idx_r <= 4'd0;
            bit_cnt_r  <= 3'd0;
            par_bad_r  <= 1'b0;
        end else begin
            if (tick_s) begin
                samp_idx_r <= samp_idx_r + 4'd1;
            end
            if (tick_s && (samp_idx_r == IDX_S7)) begin
                samp7_r <= rx_sync_r;
            end
            if (tick_s && (samp_idx_r == IDX_S8)) begin
                samp8_r <= rx_sync_r;
            end
            if (at_decide_s && (state_r == ST_DATA)) begin
                shift_r <= {bit_s, shift_r[7:1]};
            end
            if (at_end_s && (state_r == ST_DATA)) begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end
            if (parity_err_s) begin
                par_bad_r <= 1'b1;
            end
        end
    end

    // FSM outputs: FIFO push and error strobes, all decided at tick 9.
    always_comb begin
        push_s       = 1'b0;
        frame_err_s  = 1'b0;
        parity_err_s = 1'b0;
        if (at_decide_s) begin
            case (state_r)
                ST_STOP: begin
                    if (bit_s) begin
                        push_s = ~par_bad_r;
                    end else begin
                        frame_err_s = 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    parity_err_s = (even_parity(shift_r) != bit_s);
                end
`endif
                default: begin
                    push_s       = 1'b0;
                    frame_err_s  = 1'b0;
                    parity_err_s = 1'b0;
                end
            endcase
        end else begin
            push_s       = 1'b0;
            frame_err_s  = 1'b0;
            parity_err_s = 1'b0;
        end
    end

    // Registered error pulses.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            frame_err_r  <= frame_err_s;
            parity_err_r <= parity_err_s;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_ni),
        .push    (push_s),
        .wdata   (shift_r),
        .pop     (rd_i),
        .rdata   (rdata_o),
        .empty   (fifo_empty_s),
        .full    (full_o),
        .level   (level_o),
        .overrun (overrun_o)
    );

    assign empty_o      = fifo_empty_s;
    assign irq_o        = ~fifo_empty_s;
    assign frame_err_o  = frame_err_r;
    assign parity_err_o = parity_err_r;

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter PRESCALE_W, default 16, width of prescale_i.
REQ-003 SHALL have port wb_clk_i  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port wb_rst_ni  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port en_i  input  1  receiver enable.
REQ-006 SHALL have port prescale_i  input  PRESCALE_W  wb_clk_i cycles per oversample tick, minus 1 (16 ticks per bit).
REQ-007 SHALL have port rx_i  input  1  asynchronous serial line, idle high.
REQ-008 SHALL have port rd_i  input  1  FIFO pop strobe.
REQ-009 SHALL have port rdata_o  output  8  FIFO head byte, first-word-fall-through.
REQ-010 SHALL have ports empty_o, full_o  output  1 each  FIFO status.
REQ-011 SHALL have port level_o  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-012 SHALL have ports frame_err_o, overrun_o, parity_err_o  output  1 each  single-cycle error pulses.
REQ-013 SHALL have port irq_o  output  1  high while FIFO non-empty.

Function
REQ-014 rx_i SHALL pass a 2-flop synchronizer (flops reset to 1) before any use.
REQ-015 Tick counter SHALL reload prescale_i on reaching 0 and emit one-cycle tick at 0; prescale_i=0 gives tick every cycle.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP.
REQ-017 IDLE->START on synchronized 1->0 edge; tick sample counter cleared to 0.
REQ-018 Each bit SHALL span 16 ticks; bit value = majority of samples at ticks 7, 8, 9.
REQ-019 START: majority 1 -> IDLE (glitch rejected, no push, no error); else -> DATA.
REQ-020 DATA SHALL shift 8 bits LSB first, then -> PARITY or STOP.
REQ-021 STOP sampled 0 -> frame_err_o pulse, byte dropped, -> IDLE.
REQ-022 STOP sampled 1 -> push byte at tick 9 of stop bit, -> IDLE; empty_o deasserts next cycle.
REQ-023 Push SHALL succeed when level_o<FIFO_DEPTH or rd_i asserted same cycle; otherwise overrun_o pulse, byte dropped, FIFO unchanged.
REQ-024 rd_i with empty_o high SHALL be ignored; simultaneous push+pop SHALL keep level_o unchanged.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; full_o = (level_o==FIFO_DEPTH).
REQ-026 en_i low SHALL force IDLE, hold tick counter at reload, discard partial frame, retain FIFO contents.

Reset
REQ-027 wb_rst_ni low at a clock edge SHALL force IDLE, clear FIFO (level_o=0, empty_o=1, full_o=0), rdata_o=0, all error pulses 0, irq_o=0, including mid-frame.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: PARITY state after DATA checks even parity; mismatch -> parity_err_o pulse, byte dropped, STOP still checked.
REQ-029 Macro undefined: no PARITY state, 10-bit frame, parity_err_o tied 0.

Structure
REQ-030 Package uart_pkg SHALL hold FSM state enum, OVERSAMPLE=16, SAMPLE_MID=8 constants.
REQ-031 FIFO SHALL be sub-module uart_rx_fifo (push/pop/level/full/empty); FSM and tick logic in uart_rx_core.

Verification
REQ-032 prescale_i=0, send 0xA5 8N1 -> rdata_o=0xA5, level_o=1, within 160 cycles of start edge.
REQ-033 rx_i low 4 cycles then high -> no push, no error pulse, FSM back in IDLE.
REQ-034 Send 0x3C with stop bit 0 -> one frame_err_o pulse, level_o stays 0.
REQ-035 Send 17 bytes, no reads, FIFO_DEPTH=16 -> level_o=16, full_o=1, one overrun_o on 17th, head = first byte.
REQ-036 Assert wb_rst_ni low mid-DATA of 0x55 -> level_o=0, next clean 0x81 received correctly.
REQ-037 UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> parity_err_o pulse, no push; with parity 1 -> 0x07 pushed.
